// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request port, fixed access latency, one response pulse.
// Owns a 64-bit word array; narrow stores merge into the old word, loads return extended lanes.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned LW = AW + 3;
   localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [63:0] LIMIT = 64'(DEPTH_WORDS) << 3;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RMW, S_RESP} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_we;
   logic [1:0]      r_size;
   logic            r_unsigned;
   logic [LW-1:0]   r_addr;
   logic [63:0]     r_wdata;
   logic            r_err;
   logic [63:0]     r_data;
   logic [63:0]     r_old;
   logic [63:0]     r_mem [DEPTH_WORDS];

   logic            w_accept;
   logic            w_misalign;
   logic            w_err;
   logic            w_direct;
   logic            w_access;
   logic            w_we;
   logic [1:0]      w_size;
   logic            w_uns;
   logic [LW-1:0]   w_addr;
   logic [63:0]     w_wdata;
   logic [AW-1:0]   w_idx;
   logic [5:0]      w_off;
   logic [63:0]     w_rword;
   logic [63:0]     w_lane;
   logic [63:0]     w_ext;
   logic [63:0]     w_mask;
   logic [63:0]     w_merge;
   logic            w_mem_we;
   logic [63:0]     w_mem_wd;

   assign w_accept = req_valid & req_ready;

   always_comb begin
      w_misalign = 1'b0;
      case (req_size)
         2'b01:   w_misalign = req_addr[0];
         2'b10:   w_misalign = |req_addr[1:0];
         2'b11:   w_misalign = |req_addr[2:0];
         default: w_misalign = 1'b0;
      endcase
   end

   assign w_err    = (req_addr >= LIMIT) | w_misalign;
   assign w_direct = w_accept & ~w_err & (WAIT_CYCLES == 0);
   assign w_access = w_direct | ((r_state == S_WAIT) && (r_cnt == CW'(1)));

   // With no wait states the access happens on the accept edge, so use the live request.
   assign w_we    = (r_state == S_IDLE) ? req_we           : r_we;
   assign w_size  = (r_state == S_IDLE) ? req_size         : r_size;
   assign w_uns   = (r_state == S_IDLE) ? req_unsigned     : r_unsigned;
   assign w_addr  = (r_state == S_IDLE) ? req_addr[LW-1:0] : r_addr;
   assign w_wdata = (r_state == S_IDLE) ? req_wdata        : r_wdata;

   assign w_idx   = w_addr[LW-1:3];
   assign w_off   = {w_addr[2:0], 3'b000};
   assign w_rword = r_mem[w_idx];
   assign w_lane  = w_rword >> w_off;

   always_comb begin
      w_ext  = w_lane;
      w_mask = '1;
      case (w_size)
         2'b00: begin
            w_ext  = w_uns ? {56'd0, w_lane[7:0]} : {{56{w_lane[7]}}, w_lane[7:0]};
            w_mask = 64'h0000_0000_0000_00FF;
         end
         2'b01: begin
            w_ext  = w_uns ? {48'd0, w_lane[15:0]} : {{48{w_lane[15]}}, w_lane[15:0]};
            w_mask = 64'h0000_0000_0000_FFFF;
         end
         2'b10: begin
            w_ext  = w_uns ? {32'd0, w_lane[31:0]} : {{32{w_lane[31]}}, w_lane[31:0]};
            w_mask = 64'h0000_0000_FFFF_FFFF;
         end
         default: begin
            w_ext  = w_lane;
            w_mask = '1;
         end
      endcase
   end

   assign w_merge  = (r_old & ~(w_mask << w_off)) | ((w_wdata & w_mask) << w_off);
   assign w_mem_we = ~reset & ((w_access & w_we & (w_size == 2'b11)) | (r_state == S_RMW));
   assign w_mem_wd = (r_state == S_RMW) ? w_merge : w_wdata;

   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[w_idx] <= w_mem_wd;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         r_we       <= 1'b0;
         r_size     <= '0;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_err      <= 1'b0;
         r_data     <= '0;
         r_old      <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_we       <= req_we;
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  r_addr     <= req_addr[LW-1:0];
                  r_wdata    <= req_wdata;
                  r_err      <= w_err;
                  r_data     <= '0;
                  req_ready  <= 1'b0;
                  if (w_err) begin
                     r_state <= S_RESP;
                  end else if (WAIT_CYCLES != 0) begin
                     r_state <= S_WAIT;
                     r_cnt   <= CW'(WAIT_CYCLES);
                  end
               end
            end
            S_WAIT:  r_cnt   <= r_cnt - 1'b1;
            S_RMW:   r_state <= S_RESP;
            S_RESP: begin
               rsp_valid <= 1'b1;
               rsp_rdata <= r_data;
               rsp_err   <= r_err;
               req_ready <= 1'b1;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
         // Shared access step for both the WAIT exit and the zero-latency accept edge.
         if (w_access) begin
            if (!w_we) begin
               r_data  <= w_ext;
               r_state <= S_RESP;
            end else if (w_size == 2'b11) begin
               r_state <= S_RESP;
            end else begin
               r_old   <= w_rword;
               r_state <= S_RMW;
            end
         end
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait cycles, one with none.
// Expected responses are queued at accept time and compared when the response pulse appears.
module tb_data_mem_responder;
   logic        clk = 1'b0;
   logic        reset;
   logic        v2, v0, we, uns;
   logic [1:0]  sz;
   logic [63:0] addr, wdata;
   logic        rdy2, rdy0, rv2, rv0, re2, re0;
   logic [63:0] rd2, rd0;
   logic        sel;
   logic        m_rdy, m_rv, m_re;
   logic [63:0] m_rd;
   int          checks = 0;
   int          failures = 0;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          lat;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut2 (
      .clk(clk), .reset(reset), .req_valid(v2), .req_ready(rdy2), .req_we(we),
      .req_size(sz), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
      .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(re2)
   );

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_we(we),
      .req_size(sz), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
      .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0)
   );

   assign m_rdy = sel ? rdy0 : rdy2;
   assign m_rv  = sel ? rv0  : rv2;
   assign m_re  = sel ? re0  : re2;
   assign m_rd  = sel ? rd0  : rd2;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input string tag, input logic s, input logic w, input logic [1:0] z,
                         input logic u, input logic [63:0] a, input logic [63:0] d,
                         input logic [63:0] er, input logic ee, input int elat, input bit hold);
      exp_t e;
      exp_t got;
      int   k;
      bit   seen;
      sel = s;
      @(negedge clk);
      we = w; sz = z; uns = u; addr = a; wdata = d;
      if (s) v0 = 1'b1; else v2 = 1'b1;
      k = 0;
      while (!m_rdy && k < 16) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_ready"}, 64'(m_rdy), 64'd1);
      @(posedge clk);
      e.rdata = er; e.err = ee; e.lat = elat;
      sb_q.push_back(e);
      #1;
      if (hold) begin
         we = 1'b1; sz = 2'b11; addr = a & ~64'd7; wdata = '1;
      end else begin
         v0 = 1'b0; v2 = 1'b0;
         we = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom);
         addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
      end
      seen = 1'b0;
      k = 0;
      while (!seen && k < 16) begin
         @(posedge clk);
         #1;
         k++;
         v0 = 1'b0; v2 = 1'b0;
         if (m_rv) seen = 1'b1;
         else check({tag, "_quiet"}, m_rd | 64'(m_re), 64'd0);
      end
      check({tag, "_rsp_seen"}, 64'(seen), 64'd1);
      if (sb_q.size() > 0) begin
         got = sb_q.pop_front();
         if (seen) begin
            check({tag, "_rdata"}, m_rd, got.rdata);
            check({tag, "_err"}, 64'(m_re), 64'(got.err));
            check({tag, "_latency"}, 64'(k), 64'(got.lat));
         end
      end
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, 64'(m_rv), 64'd0);
   endtask

   task automatic rst_mid(input string tag, input int at_edge);
      int k;
      bit seen;
      sel = 1'b0;
      @(negedge clk);
      we = 1'b1; sz = 2'b10; uns = 1'b0; addr = 64'h30; wdata = 64'h1234_5678; v2 = 1'b1;
      k = 0;
      while (!rdy2 && k < 16) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_ready"}, 64'(rdy2), 64'd1);
      @(posedge clk);
      #1 v2 = 1'b0;
      seen = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         reset = (i == at_edge);
         if (rv2) seen = 1'b1;
      end
      reset = 1'b0;
      check({tag, "_no_rsp"}, 64'(seen), 64'd0);
      check({tag, "_ready_after"}, 64'(rdy2), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; v2 = 1'b0; v0 = 1'b0; we = 1'b0; sz = 2'b00; uns = 1'b0;
      addr = '0; wdata = '0; sel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready2", 64'(rdy2), 64'd1);
      check("rst_valid2", 64'(rv2), 64'd0);
      check("rst_rdata2", rd2 | 64'(re2), 64'd0);
      check("rst_ready0", 64'(rdy0), 64'd1);
      check("rst_valid0", 64'(rv0) | rd0 | 64'(re0), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Two wait cycles: load/sd after 3 edges, narrow stores after 4, errors after 1.
      do_req("sd10",  1'b0, 1'b1, 2'b11, 1'b0, 64'h10, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 3, 1'b0);
      do_req("ld10",  1'b0, 1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 64'h1122_3344_5566_7788, 1'b0, 3, 1'b0);
      do_req("sb13",  1'b0, 1'b1, 2'b00, 1'b0, 64'h13, 64'hDEAD_BEEF_0000_00AB, 64'h0, 1'b0, 4, 1'b0);
      do_req("ld10b", 1'b0, 1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 64'h1122_3344_AB66_7788, 1'b0, 3, 1'b0);
      do_req("sd20",  1'b0, 1'b1, 2'b11, 1'b0, 64'h20, 64'h0000_0000_8000_0000, 64'h0, 1'b0, 3, 1'b0);
      do_req("lw20",  1'b0, 1'b0, 2'b10, 1'b0, 64'h20, 64'h0, 64'hFFFF_FFFF_8000_0000, 1'b0, 3, 1'b0);
      do_req("lwu20", 1'b0, 1'b0, 2'b10, 1'b1, 64'h20, 64'h0, 64'h0000_0000_8000_0000, 1'b0, 3, 1'b0);
      do_req("lb23",  1'b0, 1'b0, 2'b00, 1'b0, 64'h23, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3, 1'b0);
      do_req("lbu23", 1'b0, 1'b0, 2'b00, 1'b1, 64'h23, 64'h0, 64'h0000_0000_0000_0080, 1'b0, 3, 1'b0);
      do_req("lh22",  1'b0, 1'b0, 2'b01, 1'b0, 64'h22, 64'h0, 64'hFFFF_FFFF_FFFF_8000, 1'b0, 3, 1'b0);
      do_req("sh26",  1'b0, 1'b1, 2'b01, 1'b0, 64'h26, 64'h1111_2222_3333_7FFF, 64'h0, 1'b0, 4, 1'b0);
      do_req("ld20",  1'b0, 1'b0, 2'b11, 1'b0, 64'h20, 64'h0, 64'h7FFF_0000_8000_0000, 1'b0, 3, 1'b0);
      do_req("lhu26", 1'b0, 1'b0, 2'b01, 1'b1, 64'h26, 64'h0, 64'h0000_0000_0000_7FFF, 1'b0, 3, 1'b0);
      do_req("lw24",  1'b0, 1'b0, 2'b10, 1'b0, 64'h24, 64'h0, 64'h0000_0000_7FFF_0000, 1'b0, 3, 1'b0);

      // Error paths: misaligned and out of range, no array update.
      do_req("sh21_err", 1'b0, 1'b1, 2'b01, 1'b0, 64'h21, 64'hFFFF, 64'h0, 1'b1, 1, 1'b0);
      do_req("ld20_chk", 1'b0, 1'b0, 2'b11, 1'b0, 64'h20, 64'h0, 64'h7FFF_0000_8000_0000, 1'b0, 3, 1'b0);
      do_req("lw22_err", 1'b0, 1'b0, 2'b10, 1'b0, 64'h22, 64'h0, 64'h0, 1'b1, 1, 1'b0);
      do_req("ld24_err", 1'b0, 1'b0, 2'b11, 1'b0, 64'h24, 64'h0, 64'h0, 1'b1, 1, 1'b0);
      do_req("ld800_err", 1'b0, 1'b0, 2'b11, 1'b0, 64'h800, 64'h0, 64'h0, 1'b1, 1, 1'b0);
      do_req("ldhi_err", 1'b0, 1'b0, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0, 1'b1, 1, 1'b0);
      do_req("sd7f8", 1'b0, 1'b1, 2'b11, 1'b0, 64'h7F8, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0, 1'b0, 3, 1'b0);
      do_req("ld7f8", 1'b0, 1'b0, 2'b11, 1'b0, 64'h7F8, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 3, 1'b0);
      do_req("lbu7ff", 1'b0, 1'b0, 2'b00, 1'b1, 64'h7FF, 64'h0, 64'h0000_0000_0000_00A5, 1'b0, 3, 1'b0);

      // Reset during the wait state and on the read-modify-write commit edge.
      do_req("sd30", 1'b0, 1'b1, 2'b11, 1'b0, 64'h30, 64'hCAFE_BABE_DEAD_BEEF, 64'h0, 1'b0, 3, 1'b0);
      rst_mid("rst_wait", 2);
      do_req("ld30a", 1'b0, 1'b0, 2'b11, 1'b0, 64'h30, 64'h0, 64'hCAFE_BABE_DEAD_BEEF, 1'b0, 3, 1'b0);
      rst_mid("rst_commit", 3);
      do_req("ld30b", 1'b0, 1'b0, 2'b11, 1'b0, 64'h30, 64'h0, 64'hCAFE_BABE_DEAD_BEEF, 1'b0, 3, 1'b0);

      // Zero wait cycles: load/sd after 1 edge, narrow stores after 2.
      do_req("z_sd40", 1'b1, 1'b1, 2'b11, 1'b0, 64'h40, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 1, 1'b0);
      do_req("z_sb41", 1'b1, 1'b1, 2'b00, 1'b0, 64'h41, 64'h0000_0000_0000_005A, 64'h0, 1'b0, 2, 1'b0);
      do_req("z_lh40", 1'b1, 1'b0, 2'b01, 1'b0, 64'h40, 64'h0, 64'h0000_0000_0000_5AEF, 1'b0, 1, 1'b0);
      do_req("z_ld40_hold", 1'b1, 1'b0, 2'b11, 1'b0, 64'h40, 64'h0, 64'h0123_4567_89AB_5AEF, 1'b0, 1, 1'b1);
      do_req("z_ld40", 1'b1, 1'b0, 2'b11, 1'b0, 64'h40, 64'h0, 64'h0123_4567_89AB_5AEF, 1'b0, 1, 1'b0);
      do_req("z_sw_err", 1'b1, 1'b1, 2'b10, 1'b0, 64'h42, 64'h0, 64'h0, 1'b1, 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
